bcd2bin: RTL and testbench
==========================

Name: bcd2bin

Overview:
- Multi-cycle BCD-to-binary converter. It is the inverse of the watch's binary-to-BCD display path.
- Converts packed BCD digits (from time-set entry or preset registers) into a binary count value for loading the watch counters.
- Uses reverse double-dabble (shift right, then subtract 3 from any digit ≥8), one iteration per clock.
- Start/busy/done handshake with the controlling FSM.

Parameters:
- DIGITS, 2, number of BCD digits in bcd_in.
- BIN_WIDTH, 7, width of the binary result. Must satisfy 2^BIN_WIDTH ≥ 10^DIGITS. Also sets the iteration count.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request conversion. Sampled only when busy=0.
- bcd_in  input  4*DIGITS  packed BCD, most significant digit in the top nibble. Sampled on the accepting edge only.
- binary  output  BIN_WIDTH  converted value. Held until the next conversion completes.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when binary/error are updated.
- error  output  1  registered with done; 1 if any input nibble > 9.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; binary=0, busy=0, done=0, error=0.
  - Internal shift register and iteration counter cleared.
  - Reset mid-conversion aborts the conversion: no done pulse, binary stays 0.
- States: IDLE, CONVERT.
- IDLE:
  - On a rising edge with start=1:
    - load the work register = {bcd_in, BIN_WIDTH zeros};
    - latch invalid = OR over nibbles of (nibble > 9);
    - count = BIN_WIDTH; busy←1; state←CONVERT.
  - Otherwise hold all state.
- CONVERT, on each edge:
  - Logically shift the whole (4*DIGITS + BIN_WIDTH)-bit work register right by 1.
  - Then, for each BCD nibble of the shifted value, if nibble ≥ 8, subtract 3. Both steps are combinational within one cycle.
  - count decrements.
  - On the edge where count goes 1→0:
    - binary ← low BIN_WIDTH bits of the corrected register, or 0 if invalid;
    - error ← invalid; done ← 1; busy ← 0; state ← IDLE.
- Latency:
  - done and the new binary are visible exactly BIN_WIDTH cycles after the start-accepting edge (7 cycles at defaults).
  - busy is high for exactly BIN_WIDTH cycles.
- done and error:
  - done is high for exactly one cycle.
  - error holds its value until the next done.
- start while busy=1 is ignored; there is no queueing.
- start in the cycle done=1 (busy=0) is accepted, so back-to-back conversions run with no idle gap.
- bcd_in changes after acceptance have no effect on the in-flight conversion.
- Arithmetic:
  - Per-nibble subtract is 4-bit. A corrected nibble never underflows, since correction applies only when the nibble is ≥ 8.
  - Result range is 0 .. 10^DIGITS − 1.

Test Plan:
- Reset, then start with bcd_in=8'h42 → busy=1 for 7 cycles; done pulses on the 7th edge after acceptance; binary=7'd42, error=0.
- bcd_in=8'h99 → binary=7'd99. bcd_in=8'h00 → binary=0. bcd_in=8'h59 → binary=59. Each has the same 7-cycle latency.
- bcd_in=8'hA3 (invalid nibble) → done pulses; error=1, binary=0. A following valid 8'h17 → error=0, binary=17.
- Pulse start with 8'h25; on cycle 3 pulse start again with 8'h88 and change bcd_in → single done, binary=25. Then start on the done cycle with 8'h88 → the next done arrives 7 cycles later with binary=88.
- Start 8'h63, assert reset on cycle 4 → busy=0, binary=0, no done pulse. Then a conversion of 8'h63 → binary=63.
- Sweep all valid inputs 00..99 with back-to-back starts → every binary matches its decimal value and error=0 throughout.

Source files
------------

// File: rtl/bcd2bin.sv
// Multi-cycle BCD-to-binary converter using reverse double-dabble.
// One shift-and-correct iteration per clock, with a start/busy/done handshake.
module bcd2bin #(
  parameter int DIGITS    = 2,
  parameter int BIN_WIDTH = 7
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic [BIN_WIDTH-1:0]  binary,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int WORK_W = BCD_W + BIN_WIDTH;
  localparam int CNT_W  = $clog2(BIN_WIDTH + 1);

  typedef enum logic {
    IDLE,
    CONVERT
  } state_t;

  state_t               state_q, state_d;
  logic [WORK_W-1:0]    work_q, work_d, work_step;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 invalid_q, invalid_d;
  logic [BIN_WIDTH-1:0] binary_d;
  logic                 busy_d, done_d, error_d;

  // True when any BCD nibble holds a non-decimal code (A..F).
  function automatic logic any_invalid(input logic [BCD_W-1:0] bcd);
    logic bad;
    bad = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd[4*d +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // One reverse double-dabble iteration: shift right, then pull every BCD
  // nibble that landed at 8 or above back into range by subtracting 3.
  function automatic logic [WORK_W-1:0] dabble_step(input logic [WORK_W-1:0] w);
    logic [WORK_W-1:0] s;
    logic [3:0]        nib;
    s = w >> 1;
    for (int d = 0; d < DIGITS; d++) begin
      nib = s[BIN_WIDTH + 4*d +: 4];
      if (nib >= 4'd8) s[BIN_WIDTH + 4*d +: 4] = nib - 4'd3;
    end
    return s;
  endfunction

  assign work_step = dabble_step(work_q);

  always_comb begin
    // NOTE: every target gets a default first, so no path leaves a value
    // unassigned and no latch is inferred.
    state_d   = state_q;
    work_d    = work_q;
    count_d   = count_q;
    invalid_d = invalid_q;
    binary_d  = binary;
    busy_d    = busy;
    done_d    = 1'b0;
    error_d   = error;

    case (state_q)
      IDLE: begin
        if (start) begin
          work_d    = {bcd_in, {BIN_WIDTH{1'b0}}};
          invalid_d = any_invalid(bcd_in);
          count_d   = CNT_W'(BIN_WIDTH);
          busy_d    = 1'b1;
          state_d   = CONVERT;
        end
      end

      CONVERT: begin
        work_d  = work_step;
        count_d = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) begin
          binary_d = invalid_q ? '0 : work_step[BIN_WIDTH-1:0];
          error_d  = invalid_q;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      work_q    <= '0;
      count_q   <= '0;
      invalid_q <= 1'b0;
      binary    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      count_q   <= count_d;
      invalid_q <= invalid_d;
      binary    <= binary_d;
      busy      <= busy_d;
      done      <= done_d;
      error     <= error_d;
    end
  end

endmodule

// File: tb/tb_bcd2bin.sv
// Self-checking bench for bcd2bin: directed scenarios, a full back-to-back
// sweep of valid inputs and randomized inputs against a decimal reference model.
module tb_bcd2bin;

  localparam int DIGITS    = 2;
  localparam int BIN_WIDTH = 7;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 start;
  logic [4*DIGITS-1:0]  bcd_in;
  logic [BIN_WIDTH-1:0] binary;
  logic                 busy;
  logic                 done;
  logic                 error;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  bcd2bin #(
    .DIGITS   (DIGITS),
    .BIN_WIDTH(BIN_WIDTH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .bcd_in(bcd_in),
    .binary(binary),
    .busy  (busy),
    .done  (done),
    .error (error)
  );

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Reference model: decimal digit arithmetic straight from the BCD encoding.
  function automatic logic ref_invalid(input logic [4*DIGITS-1:0] b);
    for (int i = 0; i < DIGITS; i++) if (b[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int ref_value(input logic [4*DIGITS-1:0] b);
    int v;
    int scale;
    if (ref_invalid(b)) return 0;
    v     = 0;
    scale = 1;
    for (int i = 0; i < DIGITS; i++) begin
      v     = v + int'(b[4*i +: 4]) * scale;
      scale = scale * 10;
    end
    return v;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] b;
    b[7:4] = 4'(v / 10);
    b[3:0] = 4'(v % 10);
    return b;
  endfunction

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic start_conv(input logic [7:0] b, input string tag);
    start  = 1'b1;
    bcd_in = b;
    step();
    start = 1'b0;
    check({tag, "_accept_busy"}, 32'(busy), 1);
  endtask

  // Waits (bounded) for done; `elapsed` edges since acceptance already passed.
  task automatic wait_done(input string tag, input int elapsed);
    int lat;
    int busy_cycles;
    lat         = 99;
    busy_cycles = 1 + elapsed;
    for (int i = elapsed + 1; i <= 20; i++) begin
      step();
      if (done) begin
        lat = i;
        break;
      end
      if (busy) busy_cycles++;
    end
    check({tag, "_latency"}, lat, BIN_WIDTH);
    check({tag, "_busy_cycles"}, busy_cycles, BIN_WIDTH);
    check({tag, "_busy_at_done"}, 32'(busy), 0);
  endtask

  task automatic convert(input logic [7:0] b, input string tag);
    start_conv(b, tag);
    wait_done(tag, 0);
    check({tag, "_binary"}, 32'(binary), ref_value(b));
    check({tag, "_error"}, 32'(error), 32'(ref_invalid(b)));
    step();
    check({tag, "_done_pulse"}, 32'(done), 0);
    check({tag, "_error_held"}, 32'(error), 32'(ref_invalid(b)));
  endtask

  initial begin
    int n_done;
    logic [7:0] b;

    reset  = 1'b1;
    start  = 1'b0;
    bcd_in = '0;
    repeat (2) step();
    reset = 1'b0;
    check("reset_binary", 32'(binary), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_error", 32'(error), 0);

    convert(8'h42, "c42");
    convert(8'h99, "c99");
    convert(8'h00, "c00");
    convert(8'h59, "c59");
    convert(8'hA3, "cA3");
    convert(8'h17, "c17");

    // Start while busy is ignored, and bcd_in changes do not leak in.
    start_conv(8'h25, "ign");
    step();
    step();
    start  = 1'b1;
    bcd_in = 8'h88;
    step();
    start  = 1'b0;
    bcd_in = 8'h11;
    wait_done("ign", 3);
    check("ign_binary", 32'(binary), 25);
    // Start on the done cycle is accepted immediately.
    start  = 1'b1;
    bcd_in = 8'h88;
    step();
    start = 1'b0;
    check("b2b_accept_busy", 32'(busy), 1);
    wait_done("b2b", 0);
    check("b2b_binary", 32'(binary), 88);
    step();

    // Reset mid-conversion aborts with no done pulse.
    start_conv(8'h63, "rst");
    repeat (2) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_busy", 32'(busy), 0);
    check("rst_binary", 32'(binary), 0);
    check("rst_done", 32'(done), 0);
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done) n_done++;
    end
    check("rst_no_done", n_done, 0);
    check("rst_binary_held", 32'(binary), 0);
    convert(8'h63, "c63");

    // Sweep 00..99 with start held high: each done cycle accepts the next value.
    start  = 1'b1;
    bcd_in = 8'h00;
    for (int v = 0; v < 100; v++) begin
      step();
      check("sweep_accept", 32'(busy), 1);
      n_done = 0;
      for (int i = 0; i < BIN_WIDTH - 1; i++) begin
        step();
        if (done) n_done++;
      end
      check("sweep_early_done", n_done, 0);
      step();
      check("sweep_done", 32'(done), 1);
      check("sweep_binary", 32'(binary), v);
      check("sweep_error", 32'(error), 0);
      bcd_in = to_bcd((v + 1) % 100);
    end
    start = 1'b0;
    step();
    check("sweep_idle", 32'(busy), 0);

    // Randomized inputs, roughly half valid BCD and half arbitrary bytes.
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 1) == 1) b = to_bcd(int'($urandom_range(0, 99)));
      else                           b = 8'($urandom_range(0, 255));
      convert(b, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
